// File: rtl/ysyx_23060184_result_sel_stage.sv
// Purpose: keyed source select registered behind a valid/ready stage with a two-entry skid buffer.
// Latency: one cycle (beat accepted at edge N is on out_data after edge N).
// Backpressure: full throughput; one extra beat absorbed into skid after out_ready falls, in_ready is registered.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           synchronous discard of main and skid beats (err/err_sel kept)
//   in_valid/ready  upstream handshake; sel and src sampled on accept
//   sel, src        source key and flattened sources (source k at [k*DATA_W +: DATA_W])
//   out_valid/ready downstream handshake; out_data is the registered result
//   err, err_sel    sticky out-of-range flag and the key of the first offending beat
module ysyx_23060184_result_sel_stage #(
  parameter int NR_SRC = 4,
  parameter int SEL_W  = 2,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NR_SRC*DATA_W-1:0] src,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     err,
  output logic [SEL_W-1:0]         err_sel
);

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] sel_data;
  logic              sel_oor;
  logic              accept;
  logic              stall;

  // Compare against every legal key instead of indexing by sel, so an
  // out-of-range key never forms an out-of-bounds part-select; it simply
  // matches nothing and leaves the result at zero.
  always_comb begin
    sel_data = '0;
    sel_oor  = 1'b1;
    for (int k = 0; k < NR_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = src[k*DATA_W +: DATA_W];
        sel_oor  = 1'b0;
      end
    end
  end

  // in_ready depends only on the skid register, which cuts the
  // out_ready -> in_ready combinational path.
  assign in_ready = !skid_valid;
  assign accept   = in_valid & in_ready;
  assign stall    = out_valid & !out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      // Data registers hold; only the valid bits are dropped.
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (stall) begin
      if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= sel_data;
      end
    end else if (skid_valid) begin
      // in_ready is low here, so no new beat competes with the skid beat.
      out_valid  <= 1'b1;
      out_data   <= skid_data;
      skid_valid <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_data <= sel_data;
      end
    end
  end

  // Sticky error: only the first out-of-range key is recorded, and a beat
  // discarded by a concurrent flush does not count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err     <= 1'b0;
      err_sel <= '0;
    end else if (!flush && accept && sel_oor && !err) begin
      err     <= 1'b1;
      err_sel <= sel;
    end
  end

endmodule

// File: doc/ysyx_23060184_result_sel_stage.md
# ysyx_23060184_result_sel_stage

Parametrised, registered successor to the combinational writeback/operand keyed multiplexers. It selects one of `NR_SRC` data sources by an encoded key and registers the result behind a valid/ready handshake. A two-entry skid buffer gives full throughput with a registered `in_ready`. The block sits between execute and writeback, or wherever a source-select must be cut into a pipeline stage, and flags out-of-range keys instead of silently producing X.

## Interface
Parameters:
- `NR_SRC`, default 4: number of selectable sources, from 2 to 2**`SEL_W`.
- `SEL_W`, default 2: width of the select key.
- `DATA_W`, default 32: width of each source and of the result.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `flush`  input  1  synchronous discard of all buffered beats.
- `in_valid`  input  1  upstream beat present.
- `in_ready`  output  1  stage can accept; registered.
- `sel`  input  `SEL_W`  source key, sampled on accept.
- `src`  input  `NR_SRC*DATA_W`  flattened sources; source k occupies bits [k*DATA_W +: DATA_W].
- `out_valid`  output  1  result present.
- `out_ready`  input  1  downstream accepts.
- `out_data`  output  `DATA_W`  selected, registered result.
- `err`  output  1  sticky flag: an out-of-range key was accepted.
- `err_sel`  output  `SEL_W`  key captured at the first error.

## Operation
- Accept condition: `in_valid & in_ready`. Drain condition: `out_valid & out_ready`.
- Selection: `sel` < `NR_SRC` yields source `sel`. `sel` >= `NR_SRC` yields all-zero data, and the beat is still passed downstream.
- State: main register (`out_valid`, `out_data`) plus skid register (`skid_valid`, `skid_data`). `in_ready` = !`skid_valid`.
- Per-edge priority:
  1. If `flush`: `out_valid` goes to 0 and `skid_valid` goes to 0. A beat accepted in the same cycle is dropped. `out_data` and `skid_data` hold their values.
  2. Else if stalled (`out_valid & !out_ready`) and a beat is accepted: the beat goes to the skid register and `skid_valid` goes to 1. The main register holds.
  3. Else if stalled with no accept: no change.
  4. Else, when the main register is empty or draining:
     - If `skid_valid`: main takes the skid beat and `skid_valid` goes to 0. No accept is possible this cycle.
     - Otherwise: `out_valid` takes the value of the accept condition, and `out_data` loads the new beat on accept.
- Error handling: on an accepted out-of-range key with `err`=0, `err` goes to 1 and `err_sel` takes `sel`. Later errors do not update `err_sel`. `err` and `err_sel` are cleared only by `rst`; `flush` does not clear them. An accept that is dropped by `flush` does not set `err`.
- Ordering: beats leave in acceptance order. None are duplicated or lost except on `flush`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `skid_valid`=0 (so `in_ready`=1), skid data=0, `err`=0, `err_sel`=0.
- Latency: a beat accepted at edge N is visible on `out_valid`/`out_data` after edge N. It can be drained at edge N+1 at the earliest.
- Throughput: one beat per cycle while `out_ready`=1.
- Backpressure: after `out_ready` falls, at most one further beat is absorbed (into skid). `in_ready` falls after that edge.
- Recovery: after `out_ready` returns, the main beat drains. Skid moves into main on the same edge, and `in_ready` rises after that edge.
- The path from `out_ready` to `in_ready` is combinationally broken.
- Both registers full and `flush`: both empty next cycle, and `in_ready`=1 next cycle.
- `rst` asserted mid-transfer clears all state immediately, without waiting for a clock edge. Beats in flight are lost.

## Test plan
- **Reset and streaming:** deassert `rst`, hold `out_ready`=1. Feed sel=0..3 in consecutive cycles with src k=0x1000_0000+k. Required: `out_data` = 0x1000_0000, 0x1000_0001, 0x1000_0002, 0x1000_0003 on consecutive cycles, one cycle behind the inputs. `in_ready` stays 1.
- **Stall absorb:** with `out_valid`=1 holding data A, drop `out_ready` and present B (sel=2, src2=0xBEEF). Required: B is accepted, `in_ready`=0 next cycle, and `out_data` holds A. Raise `out_ready`. Required: A drains, then B = 0xBEEF appears, and `in_ready` returns to 1.
- **Out-of-range key:** with `NR_SRC`=3, accept sel=3, then sel=3 again after a valid beat. Required: `out_data`=0 for both beats, `err`=1, `err_sel`=3 latched at the first error, and `err` remains 1 after a `flush`.
- **Flush with full buffers:** fill main and skid under stall, then pulse `flush` together with `in_valid`=1. Required: `out_valid`=0 and `in_ready`=1 next cycle. The concurrent beat never appears on the output.
- **Asynchronous reset mid-stall:** with both registers full and `err`=1, assert `rst` between clock edges. Required: `out_valid`=0, `out_data`=0, `in_ready`=1 and `err`=0 before the next edge.
- **Parameter sweep:** run `NR_SRC`=2/`SEL_W`=1/`DATA_W`=64 and `NR_SRC`=8/`SEL_W`=3/`DATA_W`=32 with random traffic and random `out_ready` against a reference queue model. Required: in-order, lossless delivery, and `err` never set.
